// File: rtl/object_event_counter.sv
// rtl/object_event_counter.sv - ultrasonic object counter with hysteresis, confirm filter and BCD readout
module object_event_counter #(
   parameter int unsigned NEAR_CM   = 10,
   parameter int unsigned FAR_CM    = 12,
   parameter int unsigned CONFIRM   = 3,
   parameter int unsigned MAX_COUNT = 9999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dist_valid,
   input  logic [15:0] dist_cm,
   input  logic        clear,
   output logic [13:0] count,
   output logic        count_pulse,
   output logic        present,
   output logic [15:0] bcd,
   output logic        bcd_valid
);

   typedef enum logic [1:0] {IDLE_FAR, CONFIRM_NEAR, OCCUPIED, CONFIRM_FAR} state_t;

   localparam logic [3:0]  CONFIRM_L = 4'(CONFIRM);
   localparam logic [13:0] MAX_L     = 14'(MAX_COUNT);
   localparam logic [15:0] NEAR_L    = 16'(NEAR_CM);
   localparam logic [15:0] FAR_L     = 16'(FAR_CM);

   state_t      state_q, state_d;
   logic [3:0]  run_q, run_d, run_inc;
   logic [13:0] count_q, count_d;
   logic        pulse_q, pulse_d;
   logic        present_q, present_d;
   logic        inc, count_chg;
   logic        sample_ok, is_near, is_far;

   logic [13:0] bin_q, bin_d;
   logic [15:0] work_q, work_d, adj;
   logic [3:0]  step_q, step_d;
   logic        busy_q, busy_d;
   logic [15:0] bcd_q, bcd_d;
   logic        bvalid_q, bvalid_d;

   // A zero distance is a missing echo and never qualifies as any class.
   assign sample_ok = dist_valid && (dist_cm != '0);
   assign is_near   = dist_cm < NEAR_L;
   assign is_far    = dist_cm >= FAR_L;
   assign run_inc   = run_q + 4'd1;

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      inc     = 1'b0;
      if (clear) begin
         state_d = IDLE_FAR;
         run_d   = '0;
      end else if (sample_ok) begin
         case (state_q)
            IDLE_FAR: begin
               if (is_near) begin
                  if (CONFIRM_L == 4'd1) begin
                     state_d = OCCUPIED;
                     inc     = 1'b1;
                  end else begin
                     state_d = CONFIRM_NEAR;
                     run_d   = 4'd1;
                  end
               end
            end
            CONFIRM_NEAR: begin
               if (is_near) begin
                  if (run_inc == CONFIRM_L) begin
                     state_d = OCCUPIED;
                     run_d   = '0;
                     inc     = 1'b1;
                  end else begin
                     run_d = run_inc;
                  end
               end else begin
                  state_d = IDLE_FAR;
                  run_d   = '0;
               end
            end
            OCCUPIED: begin
               if (is_far) begin
                  if (CONFIRM_L == 4'd1) begin
                     state_d = IDLE_FAR;
                  end else begin
                     state_d = CONFIRM_FAR;
                     run_d   = 4'd1;
                  end
               end
            end
            CONFIRM_FAR: begin
               if (is_far) begin
                  if (run_inc == CONFIRM_L) begin
                     state_d = IDLE_FAR;
                     run_d   = '0;
                  end else begin
                     run_d = run_inc;
                  end
               end else if (is_near) begin
                  state_d = OCCUPIED;
                  run_d   = '0;
               end
            end
            default: begin
               state_d = IDLE_FAR;
               run_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      count_d   = count_q;
      count_chg = 1'b0;
      pulse_d   = 1'b0;
      if (clear) begin
         count_d   = '0;
         count_chg = 1'b1;
      end else if (inc) begin
         count_d   = (count_q == MAX_L) ? '0 : count_q + 14'd1;
         count_chg = 1'b1;
         pulse_d   = 1'b1;
      end
      present_d = (state_d == OCCUPIED) || (state_d == CONFIRM_FAR);
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         adj[4*i +: 4] = (work_q[4*i +: 4] >= 4'd5) ? work_q[4*i +: 4] + 4'd3 : work_q[4*i +: 4];
      end
   end

   // Double-dabble: 14 adjust-and-shift steps, then one commit cycle.
   always_comb begin
      bin_d    = bin_q;
      work_d   = work_q;
      step_d   = step_q;
      busy_d   = busy_q;
      bcd_d    = bcd_q;
      bvalid_d = bvalid_q;
      if (count_chg) begin
         bin_d    = count_d;
         work_d   = '0;
         step_d   = '0;
         busy_d   = 1'b1;
         bvalid_d = 1'b0;
      end else if (busy_q) begin
         if (step_q == 4'd14) begin
            bcd_d    = work_q;
            bvalid_d = 1'b1;
            busy_d   = 1'b0;
         end else begin
            {work_d, bin_d} = {adj, bin_q} << 1;
            step_d          = step_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE_FAR;
         run_q     <= '0;
         count_q   <= '0;
         pulse_q   <= 1'b0;
         present_q <= 1'b0;
         bin_q     <= '0;
         work_q    <= '0;
         step_q    <= '0;
         busy_q    <= 1'b0;
         bcd_q     <= '0;
         bvalid_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         count_q   <= count_d;
         pulse_q   <= pulse_d;
         present_q <= present_d;
         bin_q     <= bin_d;
         work_q    <= work_d;
         step_q    <= step_d;
         busy_q    <= busy_d;
         bcd_q     <= bcd_d;
         bvalid_q  <= bvalid_d;
      end
   end

   assign count       = count_q;
   assign count_pulse = pulse_q;
   assign present     = present_q;
   assign bcd         = bcd_q;
   assign bcd_valid   = bvalid_q;

endmodule

// File: tb/tb_object_event_counter.sv
// tb/tb_object_event_counter.sv - self-checking bench for object_event_counter
module tb_object_event_counter;

   localparam int NEAR = 10;
   localparam int FAR  = 12;
   localparam int CONF = 3;
   localparam int MAXC = 9999;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dist_valid = 1'b0;
   logic [15:0] dist_cm = '0;
   logic        clear = 1'b0;
   logic [13:0] count;
   logic        count_pulse;
   logic        present;
   logic [15:0] bcd;
   logic        bcd_valid;

   int checks = 0;
   int errors = 0;

   object_event_counter #(
      .NEAR_CM(NEAR), .FAR_CM(FAR), .CONFIRM(CONF), .MAX_COUNT(MAXC)
   ) dut (
      .clk(clk), .rst(rst), .dist_valid(dist_valid), .dist_cm(dist_cm), .clear(clear),
      .count(count), .count_pulse(count_pulse), .present(present),
      .bcd(bcd), .bcd_valid(bcd_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int to_bcd(input int v);
      return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
   endfunction

   // Model: occupancy flag plus streak of qualifying samples; BCD shown 15 edges after last change.
   bit m_occ, m_pulse, m_bvalid, m_changed;
   int m_streak, m_count, m_pending, m_age, m_bcd;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_occ = 0; m_streak = 0; m_count = 0; m_pulse = 0;
         m_bcd = 0; m_bvalid = 1; m_pending = 0; m_age = 15;
      end else begin
         m_changed = 0;
         m_pulse   = 0;
         if (clear) begin
            m_occ = 0; m_streak = 0; m_count = 0; m_changed = 1;
         end else if (dist_valid && dist_cm != 0) begin
            if (!m_occ) begin
               if (dist_cm < NEAR) begin
                  m_streak++;
                  if (m_streak == CONF) begin
                     m_occ = 1; m_streak = 0;
                     m_count = (m_count == MAXC) ? 0 : m_count + 1;
                     m_pulse = 1; m_changed = 1;
                  end
               end else begin
                  m_streak = 0;
               end
            end else begin
               if (dist_cm >= FAR) begin
                  m_streak++;
                  if (m_streak == CONF) begin
                     m_occ = 0; m_streak = 0;
                  end
               end else if (dist_cm < NEAR) begin
                  m_streak = 0;
               end
            end
         end
         if (m_changed) begin
            m_pending = m_count; m_age = 0; m_bvalid = 0;
         end else if (m_age < 15) begin
            m_age++;
            if (m_age == 15) begin
               m_bcd = to_bcd(m_pending); m_bvalid = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("cyc_count", count, m_count);
         chk("cyc_pulse", count_pulse, m_pulse);
         chk("cyc_present", present, m_occ);
         chk("cyc_bcd", bcd, m_bcd);
         chk("cyc_bcd_valid", bcd_valid, m_bvalid);
      end
   end

   task automatic sample(input int d, input bit clr = 1'b0);
      @(negedge clk);
      dist_valid = 1'b1; dist_cm = 16'(d); clear = clr;
      @(posedge clk); #1;
      dist_valid = 1'b0; clear = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      @(negedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic event_cycle();
      repeat (3) sample(5);
      repeat (3) sample(20);
   endtask

   initial begin
      #12;
      chk("rst_count", count, 0);
      chk("rst_pulse", count_pulse, 0);
      chk("rst_present", present, 0);
      chk("rst_bcd", bcd, 16'h0000);
      chk("rst_bcd_valid", bcd_valid, 1);
      @(negedge clk); #1;
      rst = 1'b0;

      // three near samples confirm one object
      sample(5); sample(5);
      chk("t1_pre_count", count, 0);
      sample(5);
      chk("t1_count", count, 1);
      chk("t1_pulse", count_pulse, 1);
      chk("t1_present", present, 1);
      chk("t1_bvalid_drop", bcd_valid, 0);
      idle(14);
      chk("t1_bvalid_n14", bcd_valid, 0);
      idle(1);
      chk("t1_bcd_n15", bcd, 16'h0001);
      chk("t1_bvalid_n15", bcd_valid, 1);
      chk("t1_pulse_gone", count_pulse, 0);

      // broken near run
      do_reset();
      sample(5); sample(5); sample(20); sample(5); sample(5);
      chk("t2_count", count, 0);
      chk("t2_present", present, 0);

      // neutral samples hold occupancy
      sample(5);
      chk("t3_count1", count, 1);
      repeat (50) sample(11);
      chk("t3_present_neutral", present, 1);
      sample(20); sample(20);
      chk("t3_present_2far", present, 1);
      sample(20);
      chk("t3_present_3far", present, 0);
      repeat (3) sample(5);
      chk("t3_count2", count, 2);

      // wrap at MAX_COUNT
      do_reset();
      for (int e = 1; e <= 9999; e++) event_cycle();
      chk("t4_count_max", count, 9999);
      idle(16);
      chk("t4_bcd_max", bcd, 16'h9999);
      chk("t4_bvalid_max", bcd_valid, 1);
      repeat (3) sample(5);
      chk("t4_count_wrap", count, 0);
      chk("t4_pulse_wrap", count_pulse, 1);
      repeat (3) sample(20);
      idle(16);
      chk("t4_bcd_wrap", bcd, 16'h0000);
      chk("t4_bvalid_wrap", bcd_valid, 1);

      // clear beats a confirming sample, then clear mid-conversion
      event_cycle();
      idle(16);
      chk("t5_bcd_one", bcd, 16'h0001);
      sample(5); sample(5); sample(5, 1'b1);
      chk("t5_count_clr", count, 0);
      chk("t5_pulse_clr", count_pulse, 0);
      chk("t5_present_clr", present, 0);
      repeat (3) sample(5);
      chk("t5_count_again", count, 1);
      idle(4);
      do_clear();
      chk("t5_count_clr2", count, 0);
      idle(14);
      chk("t5_bvalid_n14", bcd_valid, 0);
      chk("t5_bcd_hold", bcd, 16'h0001);
      idle(1);
      chk("t5_bcd_n15", bcd, 16'h0000);
      chk("t5_bvalid_n15", bcd_valid, 1);

      // asynchronous reset mid-confirm and mid-conversion; samples during reset lost
      repeat (3) sample(5);
      repeat (3) sample(20);
      sample(5);
      chk("t6_pre_bvalid", bcd_valid, 0);
      #2 rst = 1'b1;
      #1;
      chk("t6_async_count", count, 0);
      chk("t6_async_pulse", count_pulse, 0);
      chk("t6_async_present", present, 0);
      chk("t6_async_bcd", bcd, 16'h0000);
      chk("t6_async_bvalid", bcd_valid, 1);
      @(negedge clk);
      dist_valid = 1'b1; dist_cm = 16'd5;
      @(posedge clk); #1;
      dist_valid = 1'b0;
      @(negedge clk); #1;
      rst = 1'b0;
      sample(5); sample(5);
      chk("t6_lost_sample", count, 0);
      sample(5);
      chk("t6_count_after", count, 1);

      // zero-distance strobes are ignored
      do_reset();
      sample(5); sample(5);
      repeat (4) sample(0);
      chk("t7_zero_count", count, 0);
      chk("t7_zero_present", present, 0);
      sample(5);
      chk("t7_count", count, 1);
      chk("t7_present", present, 1);

      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/object_event_counter.md
OBJECT_EVENT_COUNTER -- requirements
Module: object_event_counter

Interface
REQ-001 The block SHALL have parameter NEAR_CM, default 10: a sample is "near" when dist_cm < NEAR_CM.
REQ-002 The block SHALL have parameter FAR_CM, default 12: a sample is "far" when dist_cm >= FAR_CM; FAR_CM > NEAR_CM is required.
REQ-003 The block SHALL have parameter CONFIRM, default 3: the number of consecutive qualifying samples needed to change occupancy; legal range 1..15.
REQ-004 The block SHALL have parameter MAX_COUNT, default 9999: the largest count value before wrap; legal range up to 9999.
REQ-005 Port clk, input, 1 bit: clock.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port dist_valid, input, 1 bit: one-cycle strobe that qualifies dist_cm.
REQ-008 Port dist_cm, input, 16 bits: distance sample from the ultrasonic controller.
REQ-009 Port clear, input, 1 bit: synchronous count clear.
REQ-010 Port count, output, 14 bits: binary object count.
REQ-011 Port count_pulse, output, 1 bit: one-cycle pulse on each increment.
REQ-012 Port present, output, 1 bit: an object is currently held in front of the sensor.
REQ-013 Port bcd, output, 16 bits: four BCD digits of count, thousands digit in [15:12]; intended for the LCD controller.
REQ-014 Port bcd_valid, output, 1 bit: bcd matches the current count.

Function
REQ-015 The block SHALL evaluate samples only in cycles with dist_valid=1; a dist_cm value of 0 means no echo and SHALL be ignored.
REQ-016 A sample with NEAR_CM <= dist_cm < FAR_CM is "neutral".
REQ-017 The FSM SHALL have four states, IDLE_FAR, CONFIRM_NEAR, OCCUPIED and CONFIRM_FAR, plus a 4-bit run counter.
REQ-018 IDLE_FAR: a near sample sets run=1 and moves to CONFIRM_NEAR; if CONFIRM=1, it moves directly to OCCUPIED and counts.
REQ-019 CONFIRM_NEAR: a near sample increments run; a far or neutral sample clears run and returns to IDLE_FAR.
REQ-020 When run reaches CONFIRM, the FSM SHALL enter OCCUPIED and clear run.
REQ-021 OCCUPIED: a far sample sets run=1 and moves to CONFIRM_FAR; if CONFIRM=1, it moves directly to IDLE_FAR. Near and neutral samples leave the state unchanged.
REQ-022 CONFIRM_FAR: a far sample increments run, and at run=CONFIRM the FSM SHALL go to IDLE_FAR. A near sample clears run and returns to OCCUPIED. A neutral sample holds state and run.
REQ-023 present SHALL be 1 exactly when the state is OCCUPIED or CONFIRM_FAR, registered with the state.
REQ-024 Entry into OCCUPIED from the confirm path SHALL increment count on that same edge and assert count_pulse for exactly that one cycle.
REQ-025 When an increment occurs at count=MAX_COUNT, count SHALL wrap to 0 and count_pulse SHALL still assert.
REQ-026 clear=1 SHALL set count=0, state=IDLE_FAR and run=0 on the next edge; it takes priority over a simultaneous increment, and count_pulse SHALL stay 0 in that case.
REQ-027 Any change of count (increment, wrap or clear, even clear at count=0) SHALL drop bcd_valid on the same edge and start an iterative shift-add-3 conversion of the new count, one bit per cycle, 14 iterations.
REQ-028 For a count change at edge N, bcd and bcd_valid=1 SHALL update at edge N+15; bcd SHALL hold its previous value until then.
REQ-029 A count change during a conversion SHALL abort it and restart on the newest count, with timing per REQ-028 from the new change.
REQ-030 count, bcd and FSM state SHALL be unaffected by dist_valid while clear is asserted.

Reset
REQ-031 rst=1 SHALL immediately force count=0, count_pulse=0, present=0, state IDLE_FAR, run=0, bcd=16'h0000, bcd_valid=1, and abort any conversion.
REQ-032 After rst is released, operation SHALL begin on the first rising edge; samples presented during reset SHALL be lost.

Verification
REQ-033 After reset, feed 3 valid samples of dist_cm=5 -> count=1 and a single count_pulse on the third sample's edge; present=1; bcd=16'h0001 and bcd_valid=1 15 cycles later.
REQ-034 Feed near 5, near 5, far 20, near 5, near 5 -> count stays 0, present=0, no count_pulse.
REQ-035 While OCCUPIED, feed 50 samples of 11 (neutral), then 3×20, then 3×5 -> present holds 1 through the neutral samples, drops after the third 20, and count becomes 2.
REQ-036 Drive 10000 complete events (3×5, 3×20 each) -> count reads 9999 with bcd=16'h9999 after event 9999, then 0 with bcd=16'h0000 and a count_pulse after event 10000.
REQ-037 Assert clear on the same edge as a confirming near sample, and again mid-conversion -> count=0, no count_pulse, bcd=16'h0000 15 cycles after the last clear.
REQ-038 Assert rst asynchronously mid-CONFIRM_NEAR and mid-conversion, and separately feed dist_cm=0 strobes -> outputs reach their reset values immediately without waiting for a clock edge; the 0-distance samples cause no state change.
